// File: rtl/riscv_dmem_pkg.sv
// Shared definitions for the data-memory request queue.
//
// Contents:
//   DMEM_*           default parameter values for the queue, its interface
//                    and its in-flight FIFO
//   dmem_inflight_t  bookkeeping kept per granted transaction (default tag
//                    width); the queue declares the same shape at its own
//                    TAG_BITS and hands it to the FIFO as a type parameter
//   cnt_width()      width of a 0..depth occupancy count
//   ptr_width()      width of an index into a depth-entry ring (min 1 bit)
package riscv_dmem_pkg;

  localparam int DMEM_XLEN            = 32;
  localparam int DMEM_MAX_OUTSTANDING = 4;
  localparam int DMEM_TAG_BITS        = 5;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DMEM_CNT_W = cnt_width(DMEM_MAX_OUTSTANDING);

  typedef struct packed {
    logic                     we;
    logic                     killed;
    logic [DMEM_TAG_BITS-1:0] tag;
  } dmem_inflight_t;

endpackage

// File: rtl/riscv_dmem_queue_if.sv
// Request / memory-bus / response bundle of the data-memory queue.
//
// Groups:
//   req_*  MEM-stage request (valid/ready handshake)
//   mem_*  data memory bus (request/grant, ack with read data and error)
//   rsp_*  in-order response back to the pipeline (one-cycle pulse)
//
// Modports:
//   master  the queue itself
//   slave   its surroundings (pipeline plus memory)
interface riscv_dmem_queue_if
  import riscv_dmem_pkg::*;
#(
  parameter int XLEN     = DMEM_XLEN,
  parameter int TAG_BITS = DMEM_TAG_BITS
);

  logic                req_valid;
  logic                req_ready;
  logic [XLEN-1:0]     req_adr;
  logic [XLEN-1:0]     req_d;
  logic                req_we;
  logic [XLEN/8-1:0]   req_be;
  logic [TAG_BITS-1:0] req_tag;

  logic                mem_req;
  logic [XLEN-1:0]     mem_adr;
  logic [XLEN-1:0]     mem_d;
  logic                mem_we;
  logic [XLEN/8-1:0]   mem_be;
  logic                mem_gnt;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_q;
  logic                mem_err;

  logic                rsp_valid;
  logic [XLEN-1:0]     rsp_q;
  logic                rsp_we;
  logic [TAG_BITS-1:0] rsp_tag;
  logic                rsp_err;

  modport master (
    input  req_valid, req_adr, req_d, req_we, req_be, req_tag,
    output req_ready,
    output mem_req, mem_adr, mem_d, mem_we, mem_be,
    input  mem_gnt, mem_ack, mem_q, mem_err,
    output rsp_valid, rsp_q, rsp_we, rsp_tag, rsp_err
  );

  modport slave (
    output req_valid, req_adr, req_d, req_we, req_be, req_tag,
    input  req_ready,
    input  mem_req, mem_adr, mem_d, mem_we, mem_be,
    output mem_gnt, mem_ack, mem_q, mem_err,
    input  rsp_valid, rsp_q, rsp_we, rsp_tag, rsp_err
  );

endinterface

// File: rtl/riscv_dmem_tagfifo.sv
// Circular FIFO holding the bookkeeping of granted, not yet acked
// transactions, oldest at the head.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        append push_entry at the tail
//   push_entry  entry to append
//   pop         drop the head entry (caller guarantees !empty)
//   kill_all    mark every stored entry as killed
//   head        oldest entry
//   count       occupancy 0..DEPTH
//   empty/full  occupancy flags
module riscv_dmem_tagfifo
  import riscv_dmem_pkg::*;
#(
  parameter int  DEPTH   = DMEM_MAX_OUTSTANDING,
  parameter type entry_t = dmem_inflight_t,
  localparam int CNT_W   = cnt_width(DEPTH),
  localparam int PTR_W   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             kill_all,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is defined purely by the pointers
  // and count, so stale contents are never observed.
  // Killing slots outside the valid window is harmless: a push overwrites
  // the whole entry, including the killed bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_ptr == PTR_W'(i)) begin
        mem[i] <= push_entry;
      end else if (kill_all) begin
        mem[i].killed <= 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/riscv_dmem_queue.sv
// Data-memory request queue between the MEM stage and the data bus.
// Requests pass through a single issue register onto the bus; granted
// transactions are tracked in order so acks can be turned into tagged
// responses. Flush withdraws the held request and turns acks of in-flight
// transactions into silent pops.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        kill the held request and all in-flight transactions
//   bus          req_* / mem_* / rsp_* bundle (master side)
//   outstanding  number of granted, not yet acked transactions
//   proto_err    sticky until rst: mem_ack arrived with nothing in flight
module riscv_dmem_queue
  import riscv_dmem_pkg::*;
#(
  parameter int  XLEN            = DMEM_XLEN,
  parameter int  MAX_OUTSTANDING = DMEM_MAX_OUTSTANDING,
  parameter int  TAG_BITS        = DMEM_TAG_BITS,
  localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  riscv_dmem_queue_if.master   bus,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 proto_err
);

  typedef struct packed {
    logic                we;
    logic                killed;
    logic [TAG_BITS-1:0] tag;
  } inflight_t;

  // Issue register
  logic                issue_valid;
  logic [XLEN-1:0]     issue_adr;
  logic [XLEN-1:0]     issue_d;
  logic                issue_we;
  logic [XLEN/8-1:0]   issue_be;
  logic [TAG_BITS-1:0] issue_tag;

  // Response register
  logic                rsp_valid;
  logic [XLEN-1:0]     rsp_q;
  logic                rsp_we;
  logic [TAG_BITS-1:0] rsp_tag;
  logic                rsp_err;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  inflight_t           push_entry;
  inflight_t           head;

  logic [CNT_W:0]      reserved;
  logic                req_ready;
  logic                accept;
  logic                granted;
  logic                rsp_fire;

  // The held request counts against the limit so a grant never finds the
  // FIFO full. Only registered state and grant feed ready: an ack frees its
  // slot from the next cycle, keeping mem_ack off the ready path.
  assign reserved  = {1'b0, outstanding} + (CNT_W+1)'(issue_valid);
  assign req_ready = ~flush & (~issue_valid | bus.mem_gnt)
                   & (reserved < (CNT_W+1)'(MAX_OUTSTANDING));
  assign accept    = bus.req_valid & req_ready;
  assign granted   = issue_valid & bus.mem_gnt;

  // ~fifo_full is redundant with the reserved limit; it only shields storage.
  assign fifo_push  = granted & ~fifo_full;
  assign push_entry = '{we: issue_we, killed: flush, tag: issue_tag};
  assign fifo_pop   = bus.mem_ack & ~fifo_empty;
  // An ack landing in the flush cycle still pops but must not respond.
  assign rsp_fire   = fifo_pop & ~head.killed & ~flush;

  riscv_dmem_tagfifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (inflight_t)
  ) u_tagfifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill_all   (flush),
    .head       (head),
    .count      (outstanding),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_adr   <= '0;
      issue_d     <= '0;
      issue_we    <= 1'b0;
      issue_be    <= '0;
      issue_tag   <= '0;
    end else if (accept) begin
      issue_valid <= 1'b1;
      issue_adr   <= bus.req_adr;
      issue_d     <= bus.req_d;
      issue_we    <= bus.req_we;
      issue_be    <= bus.req_be;
      issue_tag   <= bus.req_tag;
    end else if (flush || granted) begin
      issue_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_we    <= 1'b0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_q   <= bus.mem_q;
        rsp_we  <= head.we;
        rsp_tag <= head.tag;
        rsp_err <= bus.mem_err;
      end
      if (bus.mem_ack && fifo_empty) proto_err <= 1'b1;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_req   = issue_valid;
  assign bus.mem_adr   = issue_adr;
  assign bus.mem_d     = issue_d;
  assign bus.mem_we    = issue_we;
  assign bus.mem_be    = issue_be;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_q     = rsp_q;
  assign bus.rsp_we    = rsp_we;
  assign bus.rsp_tag   = rsp_tag;
  assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_riscv_dmem_queue.sv
// Bench for riscv_dmem_queue: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model (a queue of
// in-flight entries plus one held request).
module tb_riscv_dmem_queue;

  localparam int XLEN = 32;
  localparam int MAX  = 4;
  localparam int TAGB = 5;

  typedef struct {
    bit             we;
    bit             killed;
    logic [TAGB-1:0] tag;
  } m_entry_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [2:0] outstanding;
  logic proto_err;

  riscv_dmem_queue_if #(.XLEN(XLEN), .TAG_BITS(TAGB)) bus ();

  riscv_dmem_queue #(
    .XLEN            (XLEN),
    .MAX_OUTSTANDING (MAX),
    .TAG_BITS        (TAGB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus.master),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  m_entry_t        inflight[$];
  bit              held_valid;
  logic [XLEN-1:0] h_adr, h_d;
  bit              h_we;
  logic [3:0]      h_be;
  logic [TAGB-1:0] h_tag;
  bit              e_rsp_valid, e_rsp_we, e_rsp_err, e_proto;
  logic [XLEN-1:0] e_rsp_q;
  logic [TAGB-1:0] e_rsp_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input bit rv, input bit we, input logic [TAGB-1:0] tag,
                       input logic [XLEN-1:0] adr, input bit gnt, input bit ack,
                       input logic [XLEN-1:0] q = '0, input bit err = 1'b0,
                       input bit fl = 1'b0);
    bus.req_valid = rv;
    bus.req_we    = we;
    bus.req_tag   = tag;
    bus.req_adr   = adr;
    bus.req_d     = $urandom;
    bus.req_be    = 4'($urandom_range(0, 15));
    bus.mem_gnt   = gnt;
    bus.mem_ack   = ack;
    bus.mem_q     = q;
    bus.mem_err   = err;
    flush         = fl;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0);
  endtask

  task automatic model_reset();
    inflight.delete();
    held_valid  = 0;
    h_adr = '0; h_d = '0; h_we = 0; h_be = '0; h_tag = '0;
    e_rsp_valid = 0; e_rsp_q = '0; e_rsp_we = 0; e_rsp_tag = '0; e_rsp_err = 0;
    e_proto     = 0;
  endtask

  task automatic check_outputs();
    check("mem_req", bus.mem_req, held_valid);
    if (held_valid) begin
      check("mem_adr", bus.mem_adr, h_adr);
      check("mem_d",   bus.mem_d,   h_d);
      check("mem_we",  bus.mem_we,  h_we);
      check("mem_be",  bus.mem_be,  h_be);
    end
    check("outstanding", outstanding, inflight.size());
    check("rsp_valid", bus.rsp_valid, e_rsp_valid);
    if (e_rsp_valid) begin
      check("rsp_q",   bus.rsp_q,   e_rsp_q);
      check("rsp_we",  bus.rsp_we,  e_rsp_we);
      check("rsp_tag", bus.rsp_tag, e_rsp_tag);
      check("rsp_err", bus.rsp_err, e_rsp_err);
    end
    check("proto_err", proto_err, e_proto);
  endtask

  // One clock: check ready before the edge, advance model and DUT, check after.
  task automatic tick();
    bit       exp_ready, accept, granted;
    int       reserved;
    m_entry_t e;
    #1;
    reserved  = inflight.size() + (held_valid ? 1 : 0);
    exp_ready = !flush && (!held_valid || bus.mem_gnt) && (reserved < MAX);
    check("req_ready", bus.req_ready, exp_ready);
    accept  = bus.req_valid && exp_ready;
    granted = held_valid && bus.mem_gnt;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      e_rsp_valid = 0;
      if (bus.mem_ack) begin
        if (inflight.size() == 0) begin
          e_proto = 1;
        end else begin
          e = inflight.pop_front();
          if (!e.killed && !flush) begin
            e_rsp_valid = 1;
            e_rsp_q     = bus.mem_q;
            e_rsp_we    = e.we;
            e_rsp_tag   = e.tag;
            e_rsp_err   = bus.mem_err;
          end
        end
      end
      if (flush) foreach (inflight[i]) inflight[i].killed = 1;
      if (granted) inflight.push_back('{we: h_we, killed: flush, tag: h_tag});
      if (accept) begin
        held_valid = 1;
        h_adr = bus.req_adr; h_d = bus.req_d; h_we = bus.req_we;
        h_be  = bus.req_be;  h_tag = bus.req_tag;
      end else if (flush || granted) begin
        held_valid = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  // Grant and ack until the model is empty, bounded.
  task automatic drain();
    for (int n = 0; n < 20 && (inflight.size() > 0 || held_valid); n++) begin
      drive(0, 0, '0, '0, 1, inflight.size() > 0, $urandom);
      tick();
    end
    check("drain_outstanding", outstanding, 0);
    check("drain_mem_req", bus.mem_req, 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("rst_mem_adr", bus.mem_adr, 0);
    check("rst_rsp_q", bus.rsp_q, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    check("rst_outstanding", outstanding, 0);

    // Single load
    drive(1, 0, 5'd3, 32'h100, 0, 0);
    tick();
    check("load_mem_req", bus.mem_req, 1);
    check("load_mem_adr", bus.mem_adr, 32'h100);
    drive(0, 0, '0, '0, 1, 0);
    tick();
    check("load_granted", outstanding, 1);
    idle();
    tick();
    drive(0, 0, '0, '0, 0, 1, 32'hDEADBEEF);
    tick();
    check("load_rsp_valid", bus.rsp_valid, 1);
    check("load_rsp_q", bus.rsp_q, 32'hDEADBEEF);
    check("load_rsp_tag", bus.rsp_tag, 3);
    check("load_rsp_we", bus.rsp_we, 0);
    check("load_rsp_err", bus.rsp_err, 0);
    idle();
    tick();
    check("load_rsp_pulse", bus.rsp_valid, 0);

    // Full pipelining
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 5'(10 + i), 32'($urandom), 1, 0);
      tick();
    end
    check("full_outstanding", outstanding, 4);
    drive(1, 0, 5'd15, 32'h200, 1, 1, 32'h11);
    #1;
    check("full_ready_in_ack_cycle", bus.req_ready, 0);
    tick();
    check("full_first_rsp_tag", bus.rsp_tag, 10);
    drive(0, 0, '0, '0, 0, 0);
    #1;
    check("full_ready_after_ack", bus.req_ready, 1);
    tick();
    drain();

    // In-order tags 7, 8, 9
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5'(7 + i), 32'($urandom), 1, 0);
      tick();
    end
    drive(0, 0, '0, '0, 1, 0);
    tick();
    check("order_outstanding", outstanding, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, '0, 0, 1, 32'(i + 1));
      tick();
      check("order_rsp_valid", bus.rsp_valid, 1);
      check("order_rsp_tag", bus.rsp_tag, 7 + i);
      check("order_rsp_q", bus.rsp_q, i + 1);
    end

    // Flush with two in flight and one held
    drive(1, 0, 5'd1, 32'h300, 0, 0); tick();
    drive(1, 0, 5'd2, 32'h304, 1, 0); tick();
    drive(1, 0, 5'd3, 32'h308, 1, 0); tick();
    check("flush_pre_outstanding", outstanding, 2);
    check("flush_pre_mem_req", bus.mem_req, 1);
    drive(0, 0, '0, '0, 0, 0, '0, 0, 1);
    tick();
    check("flush_mem_req", bus.mem_req, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, '0, 0, 1, 32'hBAD);
      tick();
      check("flush_no_rsp", bus.rsp_valid, 0);
    end
    check("flush_outstanding", outstanding, 0);
    check("flush_proto", proto_err, 0);

    // Error response on a store
    drive(1, 1, 5'd4, 32'h400, 0, 0); tick();
    drive(0, 0, '0, '0, 1, 0); tick();
    drive(0, 0, '0, '0, 0, 1, 32'h77, 1); tick();
    check("err_rsp_err", bus.rsp_err, 1);
    check("err_rsp_we", bus.rsp_we, 1);

    // Simultaneous grant and ack at outstanding 2
    drive(1, 0, 5'd20, 32'h500, 0, 0); tick();
    drive(1, 0, 5'd21, 32'h504, 1, 0); tick();
    drive(1, 0, 5'd22, 32'h508, 1, 0); tick();
    drive(0, 0, '0, '0, 1, 1, 32'h55);
    tick();
    check("sim_outstanding", outstanding, 2);
    check("sim_rsp_tag", bus.rsp_tag, 20);
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom),
            $urandom, $urandom_range(0, 2) != 0,
            inflight.size() > 0 && $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      tick();
    end
    drain();

    // Ack with nothing in flight
    drive(0, 0, '0, '0, 0, 1, 32'h99);
    tick();
    check("proto_set", proto_err, 1);
    check("proto_no_rsp", bus.rsp_valid, 0);
    idle();
    tick();
    tick();
    check("proto_sticky", proto_err, 1);

    // Reset mid-burst
    drive(1, 0, 5'd30, 32'h600, 0, 0); tick();
    drive(1, 0, 5'd31, 32'h604, 1, 0); tick();
    drive(1, 0, 5'd32, 32'h608, 1, 0); tick();
    rst = 1'b1;
    drive(1, 0, 5'd33, 32'h60C, 1, 1, 32'h123);
    tick();
    rst = 1'b0;
    check("rst_burst_mem_req", bus.mem_req, 0);
    check("rst_burst_mem_adr", bus.mem_adr, 0);
    check("rst_burst_outstanding", outstanding, 0);
    check("rst_burst_rsp_valid", bus.rsp_valid, 0);
    check("rst_burst_proto", proto_err, 0);
    drive(0, 0, '0, '0, 0, 1, 32'h456);
    tick();
    check("rst_late_ack_proto", proto_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_queue.md
Name: riscv_dmem_queue

Overview:
- Parametrised data-memory request queue between the core's MEM stage and the data memory bus.
- Successor to the single-outstanding dmem_req/dmem_ack interface: supports up to MAX_OUTSTANDING pipelined transactions with a request/grant/ack handshake.
- Returns responses in order, carrying a caller tag with each one.
- On flush, drops the not-yet-issued request and silently discards acks for killed in-flight transactions.

Parameters:
XLEN, 32, data/address width
MAX_OUTSTANDING, 4, max granted-but-unacked transactions plus any held issue request (>=1)
TAG_BITS, 5, width of caller tag (e.g. destination register)

Ports:
clk  input  1  clock
rst  input  1  reset
flush  input  1  kill pending and in-flight requests
req_valid  input  1  pipeline request valid
req_ready  output  1  request accepted when req_valid&req_ready
req_adr  input  XLEN  address
req_d  input  XLEN  store data
req_we  input  1  1=store
req_be  input  XLEN/8  byte enables
req_tag  input  TAG_BITS  caller tag
mem_req  output  1  bus request
mem_adr  output  XLEN  bus address
mem_d  output  XLEN  bus write data
mem_we  output  1  bus write enable
mem_be  output  XLEN/8  bus byte enables
mem_gnt  input  1  bus accepted current request
mem_ack  input  1  oldest granted transaction complete
mem_q  input  XLEN  read data, valid with mem_ack
mem_err  input  1  bus error, valid with mem_ack
rsp_valid  output  1  response valid (one-cycle pulse)
rsp_q  output  XLEN  read data
rsp_we  output  1  response belongs to a store
rsp_tag  output  TAG_BITS  tag of the request
rsp_err  output  1  bus error on this transaction
outstanding  output  $clog2(MAX_OUTSTANDING+1)  in-flight count
proto_err  output  1  sticky: mem_ack seen with no entry in flight

Behaviour:
- Single clock, clk. Reset: rst is synchronous and active-high. All registered outputs are 0 on reset, pointers and counts are 0, and any held request is discarded. Reset mid-transaction drops all state; later acks count as protocol errors.
- Issue register:
  - Holds one request.
  - mem_req is the issue register's valid bit. mem_adr, mem_d, mem_we and mem_be are driven from the register.
  - A held request is stable until mem_gnt. It is withdrawn only by flush or rst.
- reserved = outstanding + issue_valid.
- req_ready = !flush & (!issue_valid | mem_gnt) & (reserved < MAX_OUTSTANDING).
  - There is no combinational path from mem_ack to req_ready.
  - Back-to-back acceptance (1 request/cycle) is possible while grants arrive every cycle.
- Accept: the issue register loads on the next edge, so mem_req asserts 1 cycle after acceptance.
- Grant (mem_req & mem_gnt):
  - Push {we, tag, killed=0} into the in-flight FIFO.
  - Write pointer wraps from MAX_OUTSTANDING-1 to 0.
  - outstanding increments.
- Ack (mem_ack & outstanding>0):
  - Pop the head; outstanding decrements.
  - If the entry is not killed, on the next cycle: rsp_valid=1, rsp_q=registered mem_q, rsp_we/rsp_tag from the entry, rsp_err=registered mem_err.
  - Response latency is 1 cycle after ack. Stores also produce a response.
- Simultaneous grant and ack: push and pop in the same cycle; outstanding is unchanged. When full, the pop frees a slot only from the next cycle.
- Ack with outstanding==0: ignored, no response, proto_err set until rst.
- Flush:
  - The issue register is cleared unless granted in the same cycle; in that case its entry is pushed with killed=1.
  - Every in-flight entry gets killed=1.
  - req_ready=0 during the flush cycle.
  - Acks for killed entries pop silently: no rsp_valid and no proto_err.
  - An ack in the flush cycle pops normally, but its response is suppressed.
- Responses are strictly in grant order.

Decomposition:
- Package riscv_dmem_pkg:
  - typedef dmem_inflight_t {logic we; logic killed; logic [TAG_BITS-1:0] tag;} (or its equivalent parameterised width)
  - localparam for count width
- Sub-module riscv_dmem_tagfifo:
  - Circular FIFO with push, pop and kill_all (sets killed on all valid entries).
  - Exposes head, count, empty and full.
  - Parameter DEPTH=MAX_OUTSTANDING.

Test Plan:
- Single load: req adr=0x100 tag=3, mem_gnt the same cycle mem_req rises, mem_ack 2 cycles later with q=0xDEADBEEF -> one rsp_valid pulse 1 cycle after ack, rsp_q=0xDEADBEEF, rsp_tag=3, rsp_we=0, rsp_err=0.
- Full pipelining: MAX_OUTSTANDING=4, req_valid held, gnt always 1, no ack -> 4 grants, outstanding=4, req_ready=0. One ack -> req_ready=1 the following cycle, never in the ack cycle.
- In-order tags: 3 requests with tags 7,8,9, acks on 3 consecutive cycles with q=1,2,3 -> responses (7,1),(8,2),(9,3) on 3 consecutive cycles.
- Flush: 2 in flight plus 1 held (no gnt), assert flush -> mem_req low the next cycle. The following 2 acks produce no rsp_valid; outstanding returns to 0; proto_err=0.
- Error/protocol: ack with mem_err=1 -> rsp_err=1. Ack with outstanding=0 -> proto_err=1 and sticky until rst. Synchronous rst mid-burst -> all outputs 0 the next cycle.
- Simultaneous grant+ack at outstanding=2 -> outstanding stays 2 and the response carries the oldest tag.
